iob_2p_assim_fifo_w_big: RTL and testbench

Single-clock asymmetric FIFO with a wide write port and a narrow read port, built on a two-port narrow-word RAM. It accepts one W_DATA_W word per write and returns it as RATIO = W_DATA_W/R_DATA_W consecutive R_DATA_W words, least-significant slice first. It is the wide-to-narrow counterpart of the narrow-to-wide assimetric memory. Typical uses are serialising 32-bit bus data into a byte-oriented consumer (UART TX, SPI, and similar).

---
 rtl/iob_2p_assim_fifo_w_big_if.sv | 37 +++
 rtl/iob_2p_assim_fifo_w_big.sv | 84 ++++++++
 tb/tb_iob_2p_assim_fifo_w_big.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iob_2p_assim_fifo_w_big_if.sv
// iob_2p_assim_fifo_w_big_if: write/read handshake bundle for the wide-to-narrow FIFO.
// With IOB_ASSIM_FIFO_ERR_EN defined the bundle also carries the sticky
// w_overflow / r_underflow error flags.
`timescale 1ns/1ps
interface iob_2p_assim_fifo_w_big_if #(
    parameter int W_DATA_W = 32,
    parameter int R_DATA_W = 8,
    parameter int ADDR_W   = 7
);
    logic                w_en;
    logic [W_DATA_W-1:0] w_data;
    logic                w_full;
    logic                r_en;
    logic [R_DATA_W-1:0] r_data;
    logic                r_empty;
    logic [ADDR_W:0]     level;
`ifdef IOB_ASSIM_FIFO_ERR_EN
    logic                w_overflow;
    logic                r_underflow;
`endif

    modport master (
        output w_en, w_data, r_en,
`ifdef IOB_ASSIM_FIFO_ERR_EN
        input  w_overflow, r_underflow,
`endif
        input  w_full, r_data, r_empty, level
    );

    modport slave (
        input  w_en, w_data, r_en,
`ifdef IOB_ASSIM_FIFO_ERR_EN
        output w_overflow, r_underflow,
`endif
        output w_full, r_data, r_empty, level
    );
endinterface

// File: rtl/iob_2p_assim_fifo_w_big.sv
// iob_2p_assim_fifo_w_big: single-clock asymmetric FIFO, one wide word in,
// RATIO narrow words out (least-significant slice first), stored in a
// narrow-word two-port RAM. Optional sticky error flags are enabled by
// defining IOB_ASSIM_FIFO_ERR_EN.
`timescale 1ns/1ps
module iob_2p_assim_fifo_w_big #(
    parameter int W_DATA_W = 32,
    parameter int R_DATA_W = 8,
    parameter int ADDR_W   = 7
) (
    input logic clk,
    input logic rst,
    iob_2p_assim_fifo_w_big_if.slave bus
);
    localparam int RATIO   = W_DATA_W / R_DATA_W;
    localparam int RATIO_W = $clog2(RATIO);
    localparam int WPTR_W  = ADDR_W - RATIO_W;
    localparam int CAP     = 2 ** ADDR_W;

    localparam logic [ADDR_W:0] RATIO_L = (ADDR_W+1)'(RATIO);
    localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);
    // Above this occupancy a whole wide word no longer fits.
    localparam logic [ADDR_W:0] FULL_TH = (ADDR_W+1)'(CAP - RATIO);

    logic [R_DATA_W-1:0] ram [0:CAP-1];
    logic [WPTR_W-1:0]   wptr;
    logic [ADDR_W-1:0]   rptr;
    logic                w_acc;
    logic                r_acc;
    logic [ADDR_W:0]     level_nxt;

    // Acceptance is judged on registered flags; occupancy after this edge.
    always_comb begin
        w_acc     = bus.w_en && !bus.w_full;
        r_acc     = bus.r_en && !bus.r_empty;
        level_nxt = bus.level;
        if (w_acc) level_nxt = level_nxt + RATIO_L;
        if (r_acc) level_nxt = level_nxt - ONE_L;
    end

    // Wide write scatters into RATIO consecutive narrow locations, LS slice at lowest address.
    always_ff @(posedge clk) begin
        if (w_acc) begin
            for (int i = 0; i < RATIO; i++) begin
                ram[{wptr, RATIO_W'(i)}] <= bus.w_data[i*R_DATA_W +: R_DATA_W];
            end
        end
    end

    // Pointers, occupancy, flags and registered read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr        <= '0;
            rptr        <= '0;
            bus.level   <= '0;
            bus.r_data  <= '0;
            bus.r_empty <= 1'b1;
            bus.w_full  <= 1'b0;
        end else begin
            if (w_acc) wptr <= wptr + 1'b1;
            if (r_acc) begin
                bus.r_data <= ram[rptr];
                rptr       <= rptr + 1'b1;
            end
            bus.level   <= level_nxt;
            bus.r_empty <= (level_nxt == '0);
            bus.w_full  <= (level_nxt > FULL_TH);
        end
    end

`ifdef IOB_ASSIM_FIFO_ERR_EN
    // Sticky misuse flags: write while full, read while empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.w_overflow  <= 1'b0;
            bus.r_underflow <= 1'b0;
        end else begin
            if (bus.w_en && bus.w_full)  bus.w_overflow  <= 1'b1;
            if (bus.r_en && bus.r_empty) bus.r_underflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_iob_2p_assim_fifo_w_big.sv
// tb_iob_2p_assim_fifo_w_big: randomized bench with a byte-queue reference model.
// Define IOB_ASSIM_FIFO_ERR_EN to also cover the sticky error flags.
`timescale 1ns/1ps
module tb_iob_2p_assim_fifo_w_big;
    localparam int W_DATA_W = 32;
    localparam int R_DATA_W = 8;
    localparam int ADDR_W   = 7;
    localparam int RATIO    = W_DATA_W / R_DATA_W;
    localparam int CAP      = 2 ** ADDR_W;

    logic clk = 1'b0;
    logic rst = 1'b1;

    iob_2p_assim_fifo_w_big_if #(.W_DATA_W(W_DATA_W), .R_DATA_W(R_DATA_W), .ADDR_W(ADDR_W)) bus ();

    iob_2p_assim_fifo_w_big #(.W_DATA_W(W_DATA_W), .R_DATA_W(R_DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model: FIFO of bytes plus the last byte read out.
    logic [R_DATA_W-1:0] q [$];
    logic [R_DATA_W-1:0] m_rdata;
    logic                m_ovf;
    logic                m_unf;

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [ADDR_W:0] m_level();
        return (ADDR_W+1)'(q.size());
    endfunction
    function automatic logic m_full();
        return q.size() > CAP - RATIO;
    endfunction
    function automatic logic m_empty();
        return q.size() == 0;
    endfunction

    task automatic model_reset();
        q.delete();
        m_rdata = '0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    // One clock of stimulus; model advances on the pre-edge occupancy.
    task automatic step(input logic we, input logic [W_DATA_W-1:0] wd, input logic re);
        logic full_b, empty_b;
        @(negedge clk);
        bus.w_en   = we;
        bus.w_data = wd;
        bus.r_en   = re;
        @(posedge clk);
        full_b  = m_full();
        empty_b = m_empty();
        if (we && full_b)  m_ovf = 1'b1;
        if (re && empty_b) m_unf = 1'b1;
        if (re && !empty_b) m_rdata = q.pop_front();
        if (we && !full_b) begin
            for (int i = 0; i < RATIO; i++) q.push_back(wd[i*R_DATA_W +: R_DATA_W]);
        end
        #1;
        bus.w_en = 1'b0;
        bus.r_en = 1'b0;
    endtask

    // Assert rst a few ns after a rising edge, i.e. in the middle of a cycle.
    task automatic async_reset_pulse_start();
        @(posedge clk);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
    endtask

    task automatic reset_release();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        async_reset_pulse_start();
        n_vec++;
        if (bus.r_empty !== 1'b1 || bus.w_full !== 1'b0 || bus.level !== '0 || bus.r_data !== '0) begin
            n_err++;
            $display("FAIL reset_idle: empty=%b full=%b level=%0d r_data=%h, want 1 0 0 00",
                     bus.r_empty, bus.w_full, bus.level, bus.r_data);
        end
        reset_release();
        for (int i = 0; i < 10; i++) step(1'b1, $urandom, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
        n_vec++;
        if (bus.level !== m_level() || bus.r_data !== m_rdata) begin
            n_err++;
            $display("FAIL reset_prefill: level=%0d r_data=%h, want %0d %h", bus.level, bus.r_data, m_level(), m_rdata);
        end
        async_reset_pulse_start();
        n_vec++;
        if (bus.r_empty !== 1'b1 || bus.w_full !== 1'b0 || bus.level !== '0 || bus.r_data !== '0) begin
            n_err++;
            $display("FAIL reset_midstream: empty=%b full=%b level=%0d r_data=%h, want 1 0 0 00",
                     bus.r_empty, bus.w_full, bus.level, bus.r_data);
        end
`ifdef IOB_ASSIM_FIFO_ERR_EN
        n_vec++;
        if (bus.w_overflow !== 1'b0 || bus.r_underflow !== 1'b0) begin
            n_err++;
            $display("FAIL reset_errflags: ovf=%b unf=%b, want 0 0", bus.w_overflow, bus.r_underflow);
        end
`endif
        reset_release();
        step(1'b1, 32'h4433_2211, 1'b0);
        for (int i = 0; i < RATIO; i++) begin
            step(1'b0, '0, 1'b1);
            n_vec++;
            if (bus.r_data !== m_rdata || bus.level !== m_level()) begin
                n_err++;
                $display("FAIL reset_fresh_read%0d: r_data=%h level=%0d, want %h %0d",
                         i, bus.r_data, bus.level, m_rdata, m_level());
            end
        end
    endtask

    task automatic test_ordering();
        logic [7:0] exp_b [4];
        exp_b[0] = 8'hAA; exp_b[1] = 8'hBB; exp_b[2] = 8'hCC; exp_b[3] = 8'hDD;
        step(1'b1, 32'hDDCC_BBAA, 1'b0);
        n_vec++;
        if (bus.level !== 8'd4 || bus.r_empty !== 1'b0) begin
            n_err++;
            $display("FAIL order_write: level=%0d empty=%b, want 4 0", bus.level, bus.r_empty);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, 1'b1);
            n_vec++;
            if (bus.r_data !== exp_b[i] || bus.level !== 8'(3 - i) || bus.r_empty !== (i == 3)) begin
                n_err++;
                $display("FAIL order_read%0d: r_data=%h level=%0d empty=%b, want %h %0d %b",
                         i, bus.r_data, bus.level, bus.r_empty, exp_b[i], 3 - i, (i == 3));
            end
        end
    endtask

    task automatic test_full_boundary();
        for (int i = 0; i < CAP / RATIO; i++) step(1'b1, $urandom, 1'b0);
        n_vec++;
        if (bus.level !== 8'd128 || bus.w_full !== 1'b1) begin
            n_err++;
            $display("FAIL full_reach: level=%0d full=%b, want 128 1", bus.level, bus.w_full);
        end
        step(1'b1, 32'hDEAD_BEEF, 1'b0);
        n_vec++;
        if (bus.level !== 8'd128 || bus.w_full !== 1'b1) begin
            n_err++;
            $display("FAIL full_ignore: level=%0d full=%b, want 128 1", bus.level, bus.w_full);
        end
`ifdef IOB_ASSIM_FIFO_ERR_EN
        n_vec++;
        if (bus.w_overflow !== 1'b1) begin
            n_err++;
            $display("FAIL full_overflow: ovf=%b, want 1", bus.w_overflow);
        end
`endif
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
        n_vec++;
        if (bus.level !== 8'd125 || bus.w_full !== 1'b1 || bus.r_data !== m_rdata) begin
            n_err++;
            $display("FAIL full_read3: level=%0d full=%b r_data=%h, want 125 1 %h", bus.level, bus.w_full, bus.r_data, m_rdata);
        end
        step(1'b0, '0, 1'b1);
        n_vec++;
        if (bus.level !== 8'd124 || bus.w_full !== 1'b0) begin
            n_err++;
            $display("FAIL full_read4: level=%0d full=%b, want 124 0", bus.level, bus.w_full);
        end
        // Drain and check every remaining byte against the model.
        while (q.size() > 0) begin
            step(1'b0, '0, 1'b1);
            n_vec++;
            if (bus.r_data !== m_rdata) begin
                n_err++;
                $display("FAIL full_drain: r_data=%h, want %h", bus.r_data, m_rdata);
            end
        end
    endtask

    task automatic test_simultaneous();
        step(1'b1, 32'h1413_1211, 1'b0);
        step(1'b1, 32'h2423_2221, 1'b1);
        n_vec++;
        if (bus.level !== 8'd7 || bus.r_data !== 8'h11) begin
            n_err++;
            $display("FAIL simul_rw: level=%0d r_data=%h, want 7 11", bus.level, bus.r_data);
        end
        while (q.size() > 0) step(1'b0, '0, 1'b1);
    endtask

    task automatic test_empty_read();
        logic [R_DATA_W-1:0] prev;
        prev = bus.r_data;
        step(1'b0, '0, 1'b1);
        n_vec++;
        if (bus.r_data !== prev || bus.level !== '0 || bus.r_empty !== 1'b1) begin
            n_err++;
            $display("FAIL empty_read: r_data=%h level=%0d empty=%b, want %h 0 1", bus.r_data, bus.level, bus.r_empty, prev);
        end
`ifdef IOB_ASSIM_FIFO_ERR_EN
        n_vec++;
        if (bus.r_underflow !== 1'b1) begin
            n_err++;
            $display("FAIL empty_underflow: unf=%b, want 1", bus.r_underflow);
        end
`endif
    endtask

    task automatic test_wrap_around();
        int nwr = 0;
        int nrd = 0;
        int cyc = 0;
        logic [W_DATA_W-1:0] wd;
        logic we, re;
        while (nrd < 300 && cyc < 3000) begin
            wd = {8'(4*nwr+3), 8'(4*nwr+2), 8'(4*nwr+1), 8'(4*nwr)};
            we = ($urandom_range(0, 3) != 0) && !m_full();
            re = ($urandom_range(0, 4) != 0) && !m_empty();
            step(we, wd, re);
            if (we) nwr++;
            if (re) begin
                n_vec++;
                if (bus.r_data !== 8'(nrd)) begin
                    n_err++;
                    $display("FAIL wrap_byte%0d: r_data=%h, want %h", nrd, bus.r_data, 8'(nrd));
                end
                nrd++;
            end
            cyc++;
        end
        n_vec++;
        if (nrd < 300) begin
            n_err++;
            $display("FAIL wrap_timeout: read %0d bytes, want 300", nrd);
        end
        n_vec++;
        if (bus.level !== m_level()) begin
            n_err++;
            $display("FAIL wrap_level: level=%0d, want %0d", bus.level, m_level());
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 2) != 0));
            n_vec++;
            if (bus.level !== m_level() || bus.w_full !== m_full() || bus.r_empty !== m_empty() || bus.r_data !== m_rdata) begin
                n_err++;
                $display("FAIL random_c%0d: level=%0d full=%b empty=%b r_data=%h, want %0d %b %b %h",
                         c, bus.level, bus.w_full, bus.r_empty, bus.r_data, m_level(), m_full(), m_empty(), m_rdata);
            end
`ifdef IOB_ASSIM_FIFO_ERR_EN
            n_vec++;
            if (bus.w_overflow !== m_ovf || bus.r_underflow !== m_unf) begin
                n_err++;
                $display("FAIL random_err_c%0d: ovf=%b unf=%b, want %b %b", c, bus.w_overflow, bus.r_underflow, m_ovf, m_unf);
            end
`endif
        end
    endtask

    initial begin
        bus.w_en   = 1'b0;
        bus.w_data = '0;
        bus.r_en   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        reset_release();
        test_reset();
        async_reset_pulse_start(); reset_release();
        test_ordering();
        async_reset_pulse_start(); reset_release();
        test_full_boundary();
        test_empty_read();
        async_reset_pulse_start(); reset_release();
        test_simultaneous();
        async_reset_pulse_start(); reset_release();
        test_wrap_around();
        async_reset_pulse_start(); reset_release();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
